// File: rtl/fec_link_pkg.sv
// Shared definitions for the FEC serial link: receiver state encoding,
// line-level constants and default widths.
package fec_link_pkg;

  // Receiver FSM states; PARITY is only visited when the
  // SERIAL_FRAME_RECEIVER_PARITY_EN build option is defined.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  localparam logic STOP_BIT  = 1'b1;
  localparam logic START_BIT = 1'b0;

  localparam int DEFAULT_DIV_WIDTH  = 8;
  localparam int DEFAULT_DATA_WIDTH = 8;

endpackage : fec_link_pkg

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs. The reset value is a
// parameter so that idle-high lines do not produce a false edge after reset.
module sync_2ff #(
  parameter int                WIDTH     = 1,
  parameter logic [WIDTH-1:0]  RESET_VAL = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_r;
  logic [WIDTH-1:0] sync_r;

  // Two-stage capture of the asynchronous input into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= RESET_VAL;
      sync_r <= RESET_VAL;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule : sync_2ff

// File: rtl/serial_frame_receiver.sv
// Receive-side deserializer for the FEC serial link. Detects a start bit on
// the synchronized rx line, samples each bit at mid-period using the trained
// divisor, assembles an LSB-first word and checks the stop bit.
// Build option: SERIAL_FRAME_RECEIVER_PARITY_EN adds an even-parity bit
// between the data and stop bits and a parity_err output.
module serial_frame_receiver
  import fec_link_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DIV_WIDTH  = DEFAULT_DIV_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DIV_WIDTH-1:0]  clk_div,
  input  logic                  enable,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  frame_err,
  output logic                  busy
`ifdef SERIAL_FRAME_RECEIVER_PARITY_EN
  ,
  output logic                  parity_err
`endif
);

  localparam int BIT_CNT_W = $clog2(DATA_WIDTH) + 1;

  localparam logic [BIT_CNT_W-1:0] BIT_ZERO = {BIT_CNT_W{1'b0}};
  localparam logic [BIT_CNT_W-1:0] BIT_ONE  = {{(BIT_CNT_W-1){1'b0}}, 1'b1};
  localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(DATA_WIDTH - 1);
  localparam logic [DIV_WIDTH-1:0] CNT_ZERO = {DIV_WIDTH{1'b0}};
  localparam logic [DIV_WIDTH-1:0] CNT_ONE  = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

`ifdef SERIAL_FRAME_RECEIVER_PARITY_EN
  localparam rx_state_e AFTER_DATA = PARITY;

  // Even parity holds when the data bits plus the parity bit have an even
  // number of ones.
  function automatic logic parity_ok(input logic [DATA_WIDTH-1:0] word,
                                     input logic                  par_bit);
    return ~(^word ^ par_bit);
  endfunction
`else
  localparam rx_state_e AFTER_DATA = STOP;
`endif

  // Input conditioning
  logic rx_sync_s;
  logic rx_prev_r;
  logic start_edge_s;

  sync_2ff #(
    .WIDTH     (1),
    .RESET_VAL (1'b1)
  ) u_rx_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_sync_s)
  );

  // Extra delay of the synchronized line for falling-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_prev_r <= 1'b1;
    end else begin
      rx_prev_r <= rx_sync_s;
    end
  end

  assign start_edge_s = rx_prev_r & ~rx_sync_s;

  // State and datapath registers
  rx_state_e             state_r,    state_n;
  logic [DIV_WIDTH-1:0]  clk_cnt_r,  clk_cnt_n;
  logic [BIT_CNT_W-1:0]  bit_cnt_r,  bit_cnt_n;
  logic [DIV_WIDTH-1:0]  div_r,      div_n;
  logic [DATA_WIDTH-1:0] shift_r,    shift_n;
  logic [DATA_WIDTH-1:0] data_out_r, data_out_n;
  logic                  valid_r,    valid_n;
  logic                  ferr_r,     ferr_n;
  logic                  busy_r;
  logic [DIV_WIDTH-1:0]  div_half_s;
  logic                  parity_good_s;

`ifdef SERIAL_FRAME_RECEIVER_PARITY_EN
  logic                  parity_r,   parity_n;
  logic                  perr_r,     perr_n;

  assign parity_good_s = parity_ok(shift_r, parity_r);
`else
  assign parity_good_s = 1'b1;
`endif

  assign div_half_s = div_r >> 1;

  // Next-state, counter and output-pulse logic for the frame FSM.
  always_comb begin
    state_n    = state_r;
    clk_cnt_n  = clk_cnt_r;
    bit_cnt_n  = bit_cnt_r;
    div_n      = div_r;
    shift_n    = shift_r;
    data_out_n = data_out_r;
    valid_n    = 1'b0;
    ferr_n     = 1'b0;
`ifdef SERIAL_FRAME_RECEIVER_PARITY_EN
    parity_n   = parity_r;
    perr_n     = 1'b0;
`endif

    if ((state_r != IDLE) && !enable) begin
      // Link dropped out of training: abandon the frame silently.
      state_n   = IDLE;
      clk_cnt_n = CNT_ZERO;
      bit_cnt_n = BIT_ZERO;
    end else begin
      case (state_r)
        IDLE: begin
          if (start_edge_s && enable && (clk_div != CNT_ZERO)) begin
            state_n   = START;
            clk_cnt_n = CNT_ZERO;
            bit_cnt_n = BIT_ZERO;
            div_n     = clk_div;
          end else begin
            state_n   = IDLE;
          end
        end

        START: begin
          if (clk_cnt_r == div_half_s) begin
            clk_cnt_n = CNT_ZERO;
            if (rx_sync_s == START_BIT) begin
              state_n = DATA;
            end else begin
              // Line went back high before mid start bit: glitch.
              state_n = IDLE;
            end
          end else begin
            clk_cnt_n = clk_cnt_r + CNT_ONE;
          end
        end

        DATA: begin
          if (clk_cnt_r == div_r) begin
            shift_n   = {rx_sync_s, shift_r[DATA_WIDTH-1:1]};
            clk_cnt_n = CNT_ZERO;
            bit_cnt_n = bit_cnt_r + BIT_ONE;
            if (bit_cnt_r == BIT_LAST) begin
              state_n = AFTER_DATA;
            end else begin
              state_n = DATA;
            end
          end else begin
            clk_cnt_n = clk_cnt_r + CNT_ONE;
          end
        end

`ifdef SERIAL_FRAME_RECEIVER_PARITY_EN
        PARITY: begin
          if (clk_cnt_r == div_r) begin
            parity_n  = rx_sync_s;
            clk_cnt_n = CNT_ZERO;
            state_n   = STOP;
          end else begin
            clk_cnt_n = clk_cnt_r + CNT_ONE;
          end
        end
`endif

        STOP: begin
          if (clk_cnt_r == div_r) begin
            state_n    = IDLE;
            clk_cnt_n  = CNT_ZERO;
            bit_cnt_n  = BIT_ZERO;
            data_out_n = shift_r;
            valid_n    = (rx_sync_s == STOP_BIT) && parity_good_s;
            ferr_n     = (rx_sync_s != STOP_BIT);
`ifdef SERIAL_FRAME_RECEIVER_PARITY_EN
            perr_n     = ~parity_good_s;
`endif
          end else begin
            clk_cnt_n  = clk_cnt_r + CNT_ONE;
          end
        end

        default: begin
          state_n   = IDLE;
          clk_cnt_n = CNT_ZERO;
          bit_cnt_n = BIT_ZERO;
        end
      endcase
    end
  end

  // State, datapath and registered-output update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      clk_cnt_r  <= CNT_ZERO;
      bit_cnt_r  <= BIT_ZERO;
      div_r      <= CNT_ZERO;
      shift_r    <= {DATA_WIDTH{1'b0}};
      data_out_r <= {DATA_WIDTH{1'b0}};
      valid_r    <= 1'b0;
      ferr_r     <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_n;
      clk_cnt_r  <= clk_cnt_n;
      bit_cnt_r  <= bit_cnt_n;
      div_r      <= div_n;
      shift_r    <= shift_n;
      data_out_r <= data_out_n;
      valid_r    <= valid_n;
      ferr_r     <= ferr_n;
      busy_r     <= (state_n != IDLE);
    end
  end

`ifdef SERIAL_FRAME_RECEIVER_PARITY_EN
  // Received parity bit and parity-error pulse register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_r <= 1'b0;
      perr_r   <= 1'b0;
    end else begin
      parity_r <= parity_n;
      perr_r   <= perr_n;
    end
  end

  assign parity_err = perr_r;
`endif

  assign data_out   = data_out_r;
  assign data_valid = valid_r;
  assign frame_err  = ferr_r;
  assign busy       = busy_r;

endmodule : serial_frame_receiver
